pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Sequencer that drives the duty (ciclo) and prescale (FINAL_VALUE) inputs of the PWM generator.
//  Accepts a ramp command over a valid/ready handshake and steps duty toward a target once every HOLD PWM periods.
//  Provides soft-start/fade for motor and LED channels and a synchronous emergency stop.
//  Sits between the control register block and one PWM generator instance.
// PARAMETERS
//  R          8    PWM counter width; duty range 0..2^R (2^R = 100 %)
//  TIMER_BITS 15   prescale width; matches the PWM FINAL_VALUE input
//  HOLD_BITS  8    width of the periods-per-step field
//  INIT_FINAL 100  final_value driven out of reset
// PORTS
//  clk          in   1            system clock
//  reset_n      in   1            asynchronous active-low reset
//  cmd_valid    in   1            command present
//  cmd_ready    out  1            command accepted on the cycle where valid&ready
//  cmd_duty     in   R+1          target duty
//  cmd_step     in   R            duty increment per step
//  cmd_hold     in   HOLD_BITS    PWM periods per step
//  cmd_final    in   TIMER_BITS   new prescale value
//  period_tick  in   1            1-cycle pulse at each PWM period end
//  stop         in   1            emergency stop, level-sensitive
//  ciclo        out  R+1          duty to PWM, registered
//  final_value  out  TIMER_BITS   prescale to PWM, registered
//  busy         out  1            ramp in progress
//  done         out  1            1-cycle pulse when ciclo reaches target
// BEHAVIOUR
//  Reset: ciclo=0, final_value=INIT_FINAL, busy=0, done=0, state=IDLE, hold_cnt=0, pend_final=0.
//  States:
//   - IDLE: cmd_ready = ~stop.
//   - RAMP: cmd_ready = 0.
//  Accept (IDLE, valid&ready): latch target=min(cmd_duty,2^R), step=max(cmd_step,1), hold=max(cmd_hold,1), and cmd_final into pend_final.
//   - Then hold_cnt=0 and go to RAMP; busy=1 from the next cycle.
//   - If target==ciclo: stay IDLE and pulse done next cycle; pend_final still applies at the next period_tick.
//  period_tick on the accept cycle is ignored for stepping and for the prescale update.
//  RAMP, on each period_tick:
//   - First tick after accept: final_value <= pend_final. The prescale only changes at period boundaries.
//   - hold_cnt++. When hold_cnt+1==hold: hold_cnt<=0 and apply a step.
//  Step, in R+1-bit unsigned arithmetic with no wrap:
//   - |target-ciclo| <= step: ciclo<=target.
//   - Else: ciclo<=ciclo±step, moving toward target.
//  On the step that reaches target: done=1 the following cycle, busy=0, return to IDLE.
//  Latency: first duty change at the hold-th period_tick after accept; N steps need N*hold ticks.
//  stop=1 (any state) on the next edge:
//   - ciclo=0, busy=0, state=IDLE, hold_cnt=0.
//   - No done pulse; final_value is unchanged; any pending prescale is discarded.
//  stop has priority over cmd_valid and period_tick in the same cycle.
//  cmd_valid while busy: held off (ready=0); the command must stay stable until accepted.
//  Full scale: ciclo=2^R is legal (100 %); ciclo never exceeds 2^R and never underflows below 0.
// STRUCTURE
//  pwm_ctrl_pkg.vh holds:
//   - state localparams IDLE=1'b0, RAMP=1'b1;
//   - full-scale constant `PWM_FULL(R) = 1<<R.
//  Sub-module pwm_step_sat (combinational):
//   - inputs cur, tgt, step;
//   - output next = saturating move toward tgt;
//   - reused by the multi-channel scheduler.
//  Top contains the FSM, hold counter and output registers. pwm_ramp_ctrl feeds ciclo/final_value of one PWM instance.
// TESTING
//  1 Reset: reset_n=0 mid-ramp -> ciclo=0, final_value=100, busy=0 asynchronously; ready=1 after release.
//  2 Up-ramp: duty=200, step=50, hold=2 from 0 -> ciclo 50,100,150,200 on ticks 2,4,6,8; one done pulse; busy 0.
//  3 Down-ramp with saturation: ciclo=256, duty=10, step=100, hold=1 -> 156,56,10 on 3 ticks.
//  4 Clamps: cmd_duty=300 (R=8) -> target 256. step=0 -> steps of 1. duty==ciclo -> done after 1 cycle, no RAMP.
//  5 Prescale: cmd_final=500 with period_tick on the accept cycle -> final_value changes only at the next tick.
//  6 Stop: stop=1 together with cmd_valid -> not accepted. stop mid-ramp at ciclo=120 -> ciclo=0 next edge, no done.

Source files
------------

// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types and helpers for the PWM duty/prescale ramp sequencer.
// The state encoding and full-scale helper are reused by the multi-channel scheduler.
package pwm_ramp_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Duty value meaning 100 % for an r-bit PWM counter.
  function automatic int unsigned pwm_full(input int unsigned r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/pwm_step_sat.sv
// Combinational saturating step: moves cur toward tgt by step, landing exactly on tgt
// when it is within reach, so the result never overshoots, wraps or underflows.
module pwm_step_sat #(
  parameter int R = 8
) (
  input  logic [R:0]   cur,
  input  logic [R:0]   tgt,
  input  logic [R-1:0] step,
  output logic [R:0]   next
);

  logic       up;
  logic [R:0] diff;
  logic [R:0] step_w;

  always_comb begin
    up     = (tgt >= cur);
    diff   = up ? (tgt - cur) : (cur - tgt);
    step_w = {1'b0, step};
    if (diff <= step_w) begin
      next = tgt;
    end else if (up) begin
      next = cur + step_w;
    end else begin
      next = cur - step_w;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp sequencer feeding ciclo/final_value of one PWM generator: accepts a ramp command,
// steps the duty toward its target every hold PWM periods, with a synchronous emergency stop.
module pwm_ramp_ctrl
  import pwm_ramp_ctrl_pkg::*;
#(
  parameter int R          = 8,
  parameter int TIMER_BITS = 15,
  parameter int HOLD_BITS  = 8,
  parameter int INIT_FINAL = 100
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [R:0]            cmd_duty,
  input  logic [R-1:0]          cmd_step,
  input  logic [HOLD_BITS-1:0]  cmd_hold,
  input  logic [TIMER_BITS-1:0] cmd_final,
  input  logic                  period_tick,
  input  logic                  stop,
  output logic [R:0]            ciclo,
  output logic [TIMER_BITS-1:0] final_value,
  output logic                  busy,
  output logic                  done
);

  localparam logic [R:0] FULL = (R+1)'(pwm_full(R));

  state_t                state, state_d;
  logic [R:0]            ciclo_d, target, target_d;
  logic [R-1:0]          step, step_d;
  logic [HOLD_BITS-1:0]  hold, hold_d, hold_cnt, hold_cnt_d;
  logic [TIMER_BITS-1:0] final_d, pend_final, pend_final_d;
  logic                  pend_valid, pend_valid_d, done_d;
  logic [R:0]            duty_clamped, step_next;
  logic [HOLD_BITS:0]    hold_cnt_inc;

  assign duty_clamped = (cmd_duty > FULL) ? FULL : cmd_duty;
  assign hold_cnt_inc = {1'b0, hold_cnt} + (HOLD_BITS+1)'(1);
  assign busy         = (state == RAMP);

  pwm_step_sat #(.R(R)) u_step_sat (
    .cur  (ciclo),
    .tgt  (target),
    .step (step),
    .next (step_next)
  );

  // NOTE: every output of this block gets a default first, so no path leaves a value
  // unassigned and no latch can be inferred.
  always_comb begin
    state_d      = state;
    ciclo_d      = ciclo;
    final_d      = final_value;
    done_d       = 1'b0;
    hold_cnt_d   = hold_cnt;
    pend_final_d = pend_final;
    pend_valid_d = pend_valid;
    target_d     = target;
    step_d       = step;
    hold_d       = hold;
    cmd_ready    = (state == IDLE) && !stop;

    if (stop) begin
      // Pending prescale is dropped; final_value keeps its current value.
      ciclo_d      = '0;
      state_d      = IDLE;
      hold_cnt_d   = '0;
      pend_valid_d = 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      // A period_tick coinciding with accept is deliberately ignored.
      target_d     = duty_clamped;
      step_d       = (cmd_step == '0) ? R'(1) : cmd_step;
      hold_d       = (cmd_hold == '0) ? HOLD_BITS'(1) : cmd_hold;
      pend_final_d = cmd_final;
      pend_valid_d = 1'b1;
      hold_cnt_d   = '0;
      if (duty_clamped == ciclo) begin
        done_d = 1'b1;
      end else begin
        state_d = RAMP;
      end
    end else if (period_tick) begin
      if (pend_valid) begin
        final_d      = pend_final;
        pend_valid_d = 1'b0;
      end
      if (state == RAMP) begin
        if (hold_cnt_inc == {1'b0, hold}) begin
          hold_cnt_d = '0;
          ciclo_d    = step_next;
          if (step_next == target) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_inc[HOLD_BITS-1:0];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ciclo       <= '0;
      final_value <= TIMER_BITS'(INIT_FINAL);
      done        <= 1'b0;
      hold_cnt    <= '0;
      pend_final  <= '0;
      pend_valid  <= 1'b0;
      target      <= '0;
      step        <= '0;
      hold        <= '0;
    end else begin
      state       <= state_d;
      ciclo       <= ciclo_d;
      final_value <= final_d;
      done        <= done_d;
      hold_cnt    <= hold_cnt_d;
      pend_final  <= pend_final_d;
      pend_valid  <= pend_valid_d;
      target      <= target_d;
      step        <= step_d;
      hold        <= hold_d;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed ramps with literal expectations, then random traffic,
// all compared every cycle against a trajectory-based reference model.
module tb_pwm_ramp_ctrl;

  localparam int R    = 8;
  localparam int TB   = 15;
  localparam int HB   = 8;
  localparam int FULL = 256;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [R:0]    cmd_duty = '0;
  logic [R-1:0]  cmd_step = '0;
  logic [HB-1:0] cmd_hold = '0;
  logic [TB-1:0] cmd_final = '0;
  logic          period_tick = 1'b0;
  logic          stop = 1'b0;
  logic [R:0]    ciclo;
  logic [TB-1:0] final_value;
  logic          busy;
  logic          done;

  pwm_ramp_ctrl #(.R(R), .TIMER_BITS(TB), .HOLD_BITS(HB), .INIT_FINAL(100)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_duty    (cmd_duty),
    .cmd_step    (cmd_step),
    .cmd_hold    (cmd_hold),
    .cmd_final   (cmd_final),
    .period_tick (period_tick),
    .stop        (stop),
    .ciclo       (ciclo),
    .final_value (final_value),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: on accept the whole duty trajectory is precomputed; the k-th entry
  // is applied on the (k*hold)-th period tick after accept.
  int m_ciclo, m_final, m_pend_final, m_hold, m_ticks;
  bit m_busy, m_done, m_pend, m_accepted;
  int m_traj[$];

  task automatic model_reset();
    m_ciclo = 0; m_final = 100; m_pend_final = 0; m_hold = 1; m_ticks = 0;
    m_busy = 0; m_done = 0; m_pend = 0; m_accepted = 0;
    m_traj.delete();
  endtask

  task automatic model_update();
    int tgt, st, c, d;
    m_accepted = 0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    m_done = 0;
    if (stop) begin
      m_ciclo = 0; m_busy = 0; m_pend = 0;
      m_traj.delete();
    end else if (!m_busy && cmd_valid) begin
      m_accepted   = 1;
      tgt          = (int'(cmd_duty) > FULL) ? FULL : int'(cmd_duty);
      st           = (cmd_step == 0) ? 1 : int'(cmd_step);
      m_hold       = (cmd_hold == 0) ? 1 : int'(cmd_hold);
      m_pend       = 1;
      m_pend_final = int'(cmd_final);
      m_ticks      = 0;
      if (tgt == m_ciclo) begin
        m_done = 1;
      end else begin
        m_traj.delete();
        c = m_ciclo;
        while (c != tgt) begin
          d = tgt - c;
          if (((d < 0) ? -d : d) <= st) c = tgt;
          else c = c + ((d > 0) ? st : -st);
          m_traj.push_back(c);
        end
        m_busy = 1;
      end
    end else if (period_tick) begin
      if (m_pend) begin
        m_final = m_pend_final;
        m_pend  = 0;
      end
      if (m_busy) begin
        m_ticks++;
        if (m_ticks % m_hold == 0) begin
          m_ciclo = m_traj.pop_front();
          if (m_traj.size() == 0) begin
            m_done = 1;
            m_busy = 0;
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check("ciclo", int'(ciclo), m_ciclo);
    check("final_value", int'(final_value), m_final);
    check("busy", int'(busy), int'(m_busy));
    check("done", int'(done), int'(m_done));
    check("cmd_ready", int'(cmd_ready), int'(!m_busy && !stop));
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic tick();
    period_tick = 1'b1;
    next_cycle();
    period_tick = 1'b0;
  endtask

  task automatic send(input int duty, input int stp, input int hld, input int fin);
    cmd_duty  = (R+1)'(duty);
    cmd_step  = R'(stp);
    cmd_hold  = HB'(hld);
    cmd_final = TB'(fin);
    cmd_valid = 1'b1;
    next_cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int exp_dn[3];
    bit have_cmd;
    exp_dn = '{156, 56, 10};
    model_reset();

    // Reset values
    repeat (2) next_cycle();
    check("rst_ciclo", int'(ciclo), 0);
    check("rst_final", int'(final_value), 100);
    check("rst_busy", int'(busy), 0);
    reset_n = 1'b1;
    next_cycle();
    check("rst_ready", int'(cmd_ready), 1);

    // Up-ramp 0 -> 200, step 50, hold 2
    send(200, 50, 2, 100);
    check("up_busy", int'(busy), 1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("up_ciclo", int'(ciclo), 50 * (k / 2));
      check("up_done", int'(done), (k == 8) ? 1 : 0);
      next_cycle();
    end
    check("up_busy_end", int'(busy), 0);
    check("up_done_low", int'(done), 0);

    // Clamp 300 -> 256, then down-ramp with saturation
    send(300, 100, 1, 100);
    tick();
    check("clamp_full", int'(ciclo), 256);
    next_cycle();
    send(10, 100, 1, 100);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("dn_ciclo", int'(ciclo), exp_dn[k]);
      next_cycle();
    end

    // step=0 -> step 1, hold=0 -> hold 1
    send(13, 0, 0, 100);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("step1_ciclo", int'(ciclo), 10 + k);
    end
    next_cycle();
    // duty == ciclo: immediate done, no RAMP
    send(13, 5, 1, 100);
    check("same_done", int'(done), 1);
    check("same_busy", int'(busy), 0);
    next_cycle();
    check("same_done_low", int'(done), 0);

    // Prescale: tick on accept cycle is ignored
    cmd_duty = 9'd20; cmd_step = 8'd7; cmd_hold = 8'd3; cmd_final = 15'd500;
    cmd_valid = 1'b1; period_tick = 1'b1;
    next_cycle();
    cmd_valid = 1'b0; period_tick = 1'b0;
    check("pre_hold", int'(final_value), 100);
    check("pre_ciclo", int'(ciclo), 13);
    next_cycle();
    tick();
    check("pre_apply", int'(final_value), 500);
    check("pre_ciclo2", int'(ciclo), 13);
    tick();
    tick();
    check("pre_target", int'(ciclo), 20);
    check("pre_done", int'(done), 1);
    next_cycle();

    // Stop beats cmd_valid
    cmd_duty = 9'd100; cmd_step = 8'd10; cmd_hold = 8'd1; cmd_final = 15'd50;
    cmd_valid = 1'b1; stop = 1'b1;
    #1;
    check("stop_ready", int'(cmd_ready), 0);
    next_cycle();
    cmd_valid = 1'b0; stop = 1'b0;
    check("stop_ciclo", int'(ciclo), 0);
    check("stop_busy", int'(busy), 0);
    next_cycle();
    check("stop_noacc", int'(busy), 0);

    // Stop mid-ramp at 120
    send(200, 40, 1, 700);
    repeat (3) tick();
    check("mid_ciclo", int'(ciclo), 120);
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    check("mid_stop_ciclo", int'(ciclo), 0);
    check("mid_stop_done", int'(done), 0);
    check("mid_stop_final", int'(final_value), 700);
    // Pending prescale discarded by stop
    send(50, 10, 1, 900);
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    tick();
    check("disc_final", int'(final_value), 700);

    // Asynchronous reset mid-ramp
    send(100, 10, 1, 300);
    tick();
    tick();
    check("ar_pre", int'(ciclo), 20);
    next_cycle();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("ar_ciclo", int'(ciclo), 0);
    check("ar_final", int'(final_value), 100);
    check("ar_busy", int'(busy), 0);
    repeat (2) next_cycle();
    reset_n = 1'b1;
    next_cycle();
    check("ar_ready", int'(cmd_ready), 1);

    // Random traffic; a command stays stable until accepted
    have_cmd = 0;
    for (int i = 0; i < 3000; i++) begin
      period_tick = ($urandom_range(0, 2) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      if (!have_cmd && $urandom_range(0, 7) == 0) begin
        have_cmd  = 1;
        cmd_duty  = (R+1)'($urandom_range(0, 300));
        cmd_step  = ($urandom_range(0, 3) == 0) ? R'($urandom_range(0, 255))
                                                : R'($urandom_range(0, 40));
        cmd_hold  = HB'($urandom_range(0, 3));
        cmd_final = TB'($urandom_range(0, 32767));
      end
      cmd_valid = have_cmd;
      next_cycle();
      if (m_accepted) have_cmd = 0;
    end
    cmd_valid = 1'b0; period_tick = 1'b0; stop = 1'b0;
    repeat (3) next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
